// File: rtl/sofa_plus_scan_pkg.sv
// sofa_plus_scan_pkg: shared state encoding, default sizes and width helper for the scan loader.
package sofa_plus_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int WORD_W_DEF = 8;
  localparam int CHAIN_LEN_DEF = 20;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sofa_plus_scan_sipo.sv
// sofa_plus_scan_sipo: collects chain-tail bits LSB-first into readback words; flush emits a short final word.
module sofa_plus_scan_sipo
  import sofa_plus_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              C,
  input  logic              R,
  input  logic              clr,
  input  logic              sample,
  input  logic              din,
  input  logic              flush,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);
  localparam int IW = cnt_w(WORD_W);
  logic [WORD_W-1:0] col_q, col_d, rb_data_q, rb_data_d, word;
  logic [IW-1:0] n_q, n_d;
  logic rb_valid_q, rb_valid_d, emit;
  always_comb begin
    word = col_q;
    word[n_q] = din;
    emit = sample && (flush || n_q == IW'(WORD_W - 1));
    col_d = (clr || emit) ? '0 : sample ? word : col_q;
    n_d = (clr || emit) ? '0 : sample ? n_q + IW'(1) : n_q;
    rb_valid_d = emit;
    rb_data_d = emit ? word : rb_data_q;
  end
  always_ff @(posedge C) begin
    if (!R) begin
      col_q <= '0;
      n_q <= '0;
      rb_valid_q <= 1'b0;
      rb_data_q <= '0;
    end else begin
      col_q <= col_d;
      n_q <= n_d;
      rb_valid_q <= rb_valid_d;
      rb_data_q <= rb_data_d;
    end
  end
  assign rb_valid = rb_valid_q;
  assign rb_data = rb_data_q;
endmodule

// File: rtl/sofa_plus_scan_loader.sv
// sofa_plus_scan_loader: streams configuration words LSB-first into the scan chain and collects the bits
// falling out of the tail as readback words.
module sofa_plus_scan_loader
  import sofa_plus_scan_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = cnt_w(CHAIN_LEN + 1)
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              scan_di,
  output logic              scan_en,
  output logic              shift_en,
  input  logic              scan_do,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);
  localparam int IW = cnt_w(WORD_W);
  state_e state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full_q, full_d, scan_di_q, scan_di_d, shift_en_q, shift_en_d;
  logic go, last_shift, last_bit, accept;
  // shift_en_q doubles as "a buffered bit shifts this cycle"; it is exactly SHIFT && buffer full
  always_comb begin
    go = state_q == IDLE && start;
    last_bit = idx_q == IW'(WORD_W - 1);
    last_shift = shift_en_q && cnt_q == CNT_W'(CHAIN_LEN - 1);
    in_ready = state_q == SHIFT && (!full_q || last_bit);
    accept = in_ready && in_valid;
    state_d = go ? SHIFT : last_shift ? DONE : (state_q == DONE) ? IDLE : state_q;
    cnt_d = go ? '0 : shift_en_q ? cnt_q + CNT_W'(1) : cnt_q;
    buf_d = accept ? in_data : buf_q;
    idx_d = (go || accept) ? '0 : shift_en_q ? idx_q + IW'(1) : idx_q;
    full_d = (go || last_shift) ? 1'b0 : accept ? 1'b1 : (shift_en_q && last_bit) ? 1'b0 : full_q;
    shift_en_d = state_d == SHIFT && full_d;
    scan_di_d = shift_en_d ? buf_d[idx_d] : scan_di_q;
  end
  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= IDLE;
      buf_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      scan_di_q <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      scan_di_q <= scan_di_d;
      shift_en_q <= shift_en_d;
    end
  end
  sofa_plus_scan_sipo #(.WORD_W(WORD_W)) u_sipo (
    .C        (C),
    .R        (R),
    .clr      (go),
    .sample   (shift_en_q),
    .din      (scan_do),
    .flush    (last_shift),
    .rb_valid (rb_valid),
    .rb_data  (rb_data)
  );
  assign scan_di = scan_di_q;
  assign shift_en = shift_en_q;
  assign scan_en = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
